// File: rtl/chrono_lap_udg.sv
// rtl/chrono_lap_udg.sv - stopwatch with debounced buttons, BCD time and 8-slot scanned display
// Optional lap/snapshot feature is built when CHRONO_LAP_EN is defined.
module chrono_lap_udg #(
  parameter int TICK_DIV = 120000,
  parameter int SCAN_DIV = 15000,
  parameter int DB_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic [6:0] seg,
  output logic [7:0] an_n,
  output logic       running,
  output logic       lap_active,
  output logic       ovf,
  output logic       tick
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);

`ifdef CHRONO_LAP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_LAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [2:0]       scan_idx_q, scan_idx_d;
  logic [1:0]       ss_sync_q, lap_sync_q;
  logic [3:0]       ss_db_q, ss_db_d, lap_db_q, lap_db_d;
  logic             ss_lvl, lap_lvl, ss_lvl_q, lap_lvl_q, ss_ev_q, lap_ev_q;
  logic [5:0][3:0]  time_q, time_d, disp;
  logic             ovf_q, ovf_d;
  logic             counting, clear_time, blank, running_q;
  logic [3:0]       cur_dig;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_n_q;
`ifdef CHRONO_LAP_EN
  logic [5:0][3:0]  snap_q;
  logic             snap_load, lap_q;
`endif

  function automatic logic [3:0] db_next(input logic s, input logic [3:0] c, input logic t);
    if (s) return 4'(DB_TICKS);
    if (t && c != 4'd0) return c - 4'd1;
    return c;
  endfunction

  function automatic logic [3:0] dig_max(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  assign ss_lvl     = (ss_db_q != 4'd0);
  assign lap_lvl    = (lap_db_q != 4'd0);
  assign ss_db_d    = db_next(ss_sync_q[1], ss_db_q, tick);
  assign lap_db_d   = db_next(lap_sync_q[1], lap_db_q, tick);

`ifdef CHRONO_LAP_EN
  assign counting   = (state_q == S_RUN) || (state_q == S_LAP);
  assign disp       = (state_q == S_LAP) ? snap_q : time_q;
  assign lap_active = lap_q;
`else
  assign counting   = (state_q == S_RUN);
  assign disp       = time_q;
  assign lap_active = 1'b0;
`endif

  // ss is examined first in every state so a simultaneous lap event is dropped
  always_comb begin
    state_d    = state_q;
    clear_time = 1'b0;
`ifdef CHRONO_LAP_EN
    snap_load  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (ss_ev_q) state_d = S_RUN;
      S_RUN: begin
        if (ss_ev_q) state_d = S_STOP;
`ifdef CHRONO_LAP_EN
        else if (lap_ev_q) begin
          state_d   = S_LAP;
          snap_load = 1'b1;
        end
`endif
      end
      S_STOP: begin
        if (ss_ev_q) state_d = S_RUN;
        else if (lap_ev_q) begin
          state_d    = S_IDLE;
          clear_time = 1'b1;
        end
      end
`ifdef CHRONO_LAP_EN
      S_LAP: begin
        if (ss_ev_q) state_d = S_STOP;
        else if (lap_ev_q) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic carry;
    time_d = time_q;
    ovf_d  = ovf_q;
    carry  = 1'b0;
    if (clear_time) begin
      time_d = '0;
      ovf_d  = 1'b0;
    end else if (tick && counting) begin
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (carry) begin
          if (time_q[i] == dig_max(i)) time_d[i] = 4'd0;
          else begin
            time_d[i] = time_q[i] + 4'd1;
            carry     = 1'b0;
          end
        end
      end
      if (carry) ovf_d = 1'b1;
    end
  end

  always_comb begin
    scan_cnt_d = (scan_cnt_q == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + SW'(1);
    scan_idx_d = (scan_cnt_q == SW'(SCAN_DIV - 1)) ? scan_idx_q + 3'd1 : scan_idx_q;
    cur_dig    = 4'd0;
    blank      = 1'b0;
    case (scan_idx_q)
      3'd0: cur_dig = disp[0];
      3'd1: cur_dig = disp[1];
      3'd2: cur_dig = disp[2];
      3'd3: cur_dig = disp[3];
      3'd4: cur_dig = disp[4];
      3'd5: cur_dig = disp[5];
      default: blank = 1'b1;
    endcase
    seg_d = blank ? 7'b0000000 : seg_dec(cur_dig);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= 3'd0;
      ss_sync_q  <= 2'b00;
      lap_sync_q <= 2'b00;
      ss_db_q    <= 4'd0;
      lap_db_q   <= 4'd0;
      ss_lvl_q   <= 1'b0;
      lap_lvl_q  <= 1'b0;
      ss_ev_q    <= 1'b0;
      lap_ev_q   <= 1'b0;
      time_q     <= '0;
      ovf_q      <= 1'b0;
      running_q  <= 1'b0;
      seg_q      <= 7'b1111110;
      an_n_q     <= 8'hFE;
`ifdef CHRONO_LAP_EN
      snap_q     <= '0;
      lap_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      ss_sync_q  <= {ss_sync_q[0], btn_ss};
      lap_sync_q <= {lap_sync_q[0], btn_lap};
      ss_db_q    <= ss_db_d;
      lap_db_q   <= lap_db_d;
      ss_lvl_q   <= ss_lvl;
      lap_lvl_q  <= lap_lvl;
      ss_ev_q    <= ss_lvl & ~ss_lvl_q;
      lap_ev_q   <= lap_lvl & ~lap_lvl_q;
      time_q     <= time_d;
      ovf_q      <= ovf_d;
      running_q  <= counting;
      seg_q      <= seg_d;
      an_n_q     <= ~(8'd1 << scan_idx_q);
`ifdef CHRONO_LAP_EN
      if (snap_load) snap_q <= time_d;
      lap_q      <= (state_q == S_LAP);
`endif
    end
  end

  assign seg     = seg_q;
  assign an_n    = an_n_q;
  assign running = running_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_chrono_lap_udg.sv
// tb/tb_chrono_lap_udg.sv - scoreboard bench for chrono_lap_udg (TICK_DIV=4, SCAN_DIV=2, DB_TICKS=2)
module tb_chrono_lap_udg;
  logic       clk = 1'b0;
  logic       rst_n, btn_ss, btn_lap;
  logic [6:0] seg;
  logic [7:0] an_n;
  logic       running, lap_active, ovf, tick;

  always #5 clk = ~clk;

  chrono_lap_udg #(.TICK_DIV(4), .SCAN_DIV(2), .DB_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .seg(seg), .an_n(an_n), .running(running), .lap_active(lap_active),
    .ovf(ovf), .tick(tick)
  );

  localparam int K_RST = 0, K_FLG = 1, K_DSP = 2, K_SCN = 3;
  typedef struct {
    int          kind;
    string       name;
    logic [23:0] disp;
    logic [2:0]  flags;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0, bad = 0;
  bit         busy = 1'b0;
  exp_t       e;
  logic [6:0] slot [8];
  int         idx, n;
  logic [23:0] obs, cur;
  logic [7:0] prev_an, exp_an;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'b1111110: return 4'd0;
      7'b0110000: return 4'd1;
      7'b1101101: return 4'd2;
      7'b1111001: return 4'd3;
      7'b0110011: return 4'd4;
      7'b1011011: return 4'd5;
      7'b1011111: return 4'd6;
      7'b1110000: return 4'd7;
      7'b1111111: return 4'd8;
      7'b1111011: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction

  function automatic int an_idx(input logic [7:0] a);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m = 8'd1 << i;
      if (a == ~m) return i;
    end
    return -1;
  endfunction

  task automatic push(input int kind, input string nm, input logic [23:0] d, input logic [2:0] f);
    exp_t x;
    x.kind = kind; x.name = nm; x.disp = d; x.flags = f;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((sb_q.size() != 0 || busy) && w < 300);
    if (w >= 300) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb_q.size());
    end
  endtask

  task automatic press(input bit lap, input int hold);
    if (lap) btn_lap = 1'b1; else btn_ss = 1'b1;
    repeat (hold) @(negedge clk);
    btn_ss = 1'b0; btn_lap = 1'b0;
  endtask

  task automatic press_both();
    btn_ss = 1'b1; btn_lap = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0; btn_lap = 1'b0;
  endtask

  // Monitor: pops one expectation at a time and observes the ports for it
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        busy = 1'b1;
        case (e.kind)
          K_RST: chk({e.name, "_regs"}, {13'd0, seg, an_n, tick, running, lap_active, ovf},
                     {13'd0, 7'b1111110, 8'hFE, 4'b0000});
          K_FLG: chk({e.name, "_flags"}, {29'd0, running, lap_active, ovf}, {29'd0, e.flags});
          K_DSP: begin
            n = 0;
            while (an_n != 8'hFE && n < 64) begin @(negedge clk); n++; end
            if (n >= 64) begin
              chk({e.name, "_scan_sync"}, 32'(n), 32'd0);
            end else begin
              for (int k = 0; k < 8; k++) slot[k] = 7'h7F;
              for (int k = 0; k < 16; k++) begin
                idx = an_idx(an_n);
                if (idx >= 0) slot[idx] = seg;
                @(negedge clk);
              end
              obs = {seg2dig(slot[5]), seg2dig(slot[4]), seg2dig(slot[3]),
                     seg2dig(slot[2]), seg2dig(slot[1]), seg2dig(slot[0])};
              chk({e.name, "_disp"}, {8'd0, obs}, {8'd0, e.disp});
              chk({e.name, "_flags"}, {29'd0, running, lap_active, ovf}, {29'd0, e.flags});
            end
          end
          K_SCN: begin
            n = 0;
            prev_an = an_n;
            @(negedge clk);
            while (!(an_n == 8'hFE && prev_an == 8'h7F) && n < 64) begin
              prev_an = an_n;
              @(negedge clk);
              n++;
            end
            if (n >= 64) begin
              chk("scan_wrap_sync", 32'(n), 32'd0);
            end else begin
              for (int k = 0; k < 32; k++) begin
                if (k % 2 == 0) begin
                  exp_an = ~(8'd1 << ((k / 2) % 8));
                  chk($sformatf("scan_an_%0d", k / 2), {24'd0, an_n}, {24'd0, exp_an});
                  if ((k / 2) % 8 >= 6) chk($sformatf("scan_blank_%0d", k / 2), {25'd0, seg}, 32'd0);
                end
                @(negedge clk);
              end
            end
          end
          default: ;
        endcase
        busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0;
    repeat (3) @(negedge clk);
    push(K_RST, "reset", 24'h0, 3'b000);
    drain();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start with a long press, stop exactly 100 ticks of run later
    press(1'b0, 12);
    repeat (20) @(negedge clk);
    push(K_FLG, "start", 24'h0, 3'b100);
    repeat (400 - 12 - 20) @(negedge clk);
    press(1'b0, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "stop_100", 24'h000100, 3'b000);
    drain();

    press(1'b1, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "clear_in_stop", 24'h000000, 3'b000);
    drain();

    // bouncing start yields one event
    btn_ss = 1'b1; @(negedge clk);
    btn_ss = 1'b0; @(negedge clk);
    btn_ss = 1'b1; @(negedge clk);
    btn_ss = 1'b0;
    repeat (4 * 37 - 3) @(negedge clk);
    press(1'b0, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "bounce_37", 24'h000037, 3'b000);
    drain();

`ifndef CHRONO_LAP_EN
    press(1'b0, 1);
    repeat (39) @(negedge clk);
    press(1'b1, 1);
    repeat (19) @(negedge clk);
    push(K_FLG, "lap_in_run", 24'h0, 3'b100);
    repeat (20) @(negedge clk);
    press(1'b0, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "lap_ignored_57", 24'h000057, 3'b000);
    drain();
    cur = 24'h000062;
`else
    press(1'b1, 1);
    repeat (20) @(negedge clk);
    press(1'b0, 1);
    repeat (147) @(negedge clk);
    press(1'b1, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "lap_snap_37", 24'h000037, 3'b110);
    repeat (71) @(negedge clk);
    press(1'b1, 1);
    repeat (20) @(negedge clk);
    push(K_FLG, "lap_release", 24'h0, 3'b100);
    repeat (59) @(negedge clk);
    press(1'b0, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "live_80", 24'h000080, 3'b000);
    drain();
    press(1'b0, 1);
    repeat (39) @(negedge clk);
    press(1'b1, 1);
    repeat (19) @(negedge clk);
    push(K_FLG, "in_lap", 24'h0, 3'b110);
    repeat (20) @(negedge clk);
    press(1'b0, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "ss_in_lap_100", 24'h000100, 3'b000);
    drain();
    cur = 24'h000105;
`endif

    // ss and lap together from RUN: ss wins, time not cleared
    press(1'b0, 1);
    repeat (19) @(negedge clk);
    press_both();
    repeat (20) @(negedge clk);
    push(K_DSP, "both_same_cycle", cur, 3'b000);
    drain();

    // wrap past 59:59.99
    dut.time_q = 24'h595999;
    repeat (2) @(negedge clk);
    press(1'b0, 1);
    repeat (39) @(negedge clk);
    push(K_FLG, "wrap_running", 24'h0, 3'b101);
    repeat (8) @(negedge clk);
    press(1'b0, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "wrap_11", 24'h000011, 3'b001);
    drain();
    press(1'b1, 1);
    repeat (20) @(negedge clk);
    push(K_DSP, "clear_ovf", 24'h000000, 3'b000);
    drain();

    push(K_SCN, "scan", 24'h0, 3'b000);
    drain();

    // reset while counting (and in LAP when present)
    press(1'b0, 1);
    repeat (30) @(negedge clk);
`ifdef CHRONO_LAP_EN
    press(1'b1, 1);
    repeat (20) @(negedge clk);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    push(K_RST, "reset_mid", 24'h0, 3'b000);
    drain();
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    push(K_DSP, "no_resume", 24'h000000, 3'b000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chrono_lap_udg.md
CHRONO_LAP_UDG -- requirements
Module: chrono_lap_udg

Interface
REQ-001 Parameter TICK_DIV, default 120000, clk cycles per 1/100 s tick.
REQ-002 Parameter SCAN_DIV, default 15000, clk cycles per display digit slot.
REQ-003 Parameter DB_TICKS, default 5, debounce hold time in ticks, range 1..15.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 btn_ss  input  1  raw start/stop button, active high, asynchronous to clk.
REQ-007 btn_lap  input  1  raw lap/clear button, active high, asynchronous to clk.
REQ-008 seg  output  7  segments a..g, active high; seg[6]=a, seg[0]=g.
REQ-009 an_n  output  8  digit cathode selects, active low, exactly one low at a time.
REQ-010 running  output  1  high in states RUN and LAP.
REQ-011 lap_active  output  1  high in state LAP.
REQ-012 ovf  output  1  sticky flag, set when the time wraps past 59:59.99.
REQ-013 tick  output  1  one-cycle pulse every TICK_DIV cycles, free-running.

Function
REQ-014 Tick counter SHALL count 0..TICK_DIV-1; tick is high in the cycle the count equals TICK_DIV-1, then the count returns to 0.
REQ-015 Each button SHALL pass through a 2-flop synchroniser.
REQ-016 Debounce: a synchronised high SHALL load the counter with DB_TICKS. Each tick SHALL decrement a nonzero counter. The debounced level is high while the counter is nonzero.
REQ-017 A button event is the rising edge of the debounced level; the FSM SHALL act on it 4 cycles after the raw input is first sampled high.
REQ-018 Time digits SHALL be BCD: cs_u 0-9, cs_d 0-9, s_u 0-9, s_d 0-5, m_u 0-9, m_d 0-5.
REQ-019 The time SHALL advance by one on tick only while running=1, with ripple carry.
REQ-020 At 59:59.99 the time SHALL wrap to 00:00.00, set ovf and keep running.
REQ-021 FSM states: IDLE, RUN, STOP, LAP.
REQ-022 IDLE: ss event -> RUN.
REQ-023 RUN: ss event -> STOP; lap event -> LAP and captures the live time into the snapshot register in the same cycle.
REQ-024 STOP: ss event -> RUN; lap event -> IDLE, clearing the time and ovf.
REQ-025 LAP: lap event -> RUN and releases the snapshot; ss event -> STOP and halts counting.
REQ-026 If ss and lap events occur in the same cycle, ss SHALL be taken and lap discarded.
REQ-027 The displayed value SHALL be the snapshot in LAP and the live time in all other states.
REQ-028 Scan index SHALL advance modulo 8 every SCAN_DIV cycles.
REQ-029 Index i SHALL drive an_n[i] low. Indices 0..5 show cs_u, cs_d, s_u, s_d, m_u, m_d. Indices 6..7 SHALL drive seg=0 (blank).
REQ-030 Digits SHALL decode to standard 7-segment 0..9; seg, an_n, running, lap_active and ovf SHALL be registered (1-cycle latency from source).

Reset
REQ-031 With rst_n low at a clk edge, the block SHALL be reset as follows:
- state=IDLE, time=00:00.00, snapshot=0, ovf=0, tick=0, running=0, lap_active=0;
- debounce, synchroniser, tick and scan counters = 0;
- an_n=8'b1111_1110, seg=7'b1111110.
REQ-032 Reset asserted mid-count or in LAP SHALL override all events in that cycle. Counting SHALL resume only after a new ss event.

Configuration
REQ-033 Macro CHRONO_LAP_EN defined: LAP state and snapshot register SHALL be present as above.
REQ-034 Macro CHRONO_LAP_EN undefined, the block SHALL behave as follows:
- LAP state and snapshot SHALL be absent, and lap_active SHALL be tied 0;
- a lap event SHALL clear the time only in STOP and SHALL be ignored in RUN and IDLE.

Verification (TICK_DIV=4, SCAN_DIV=2, DB_TICKS=2)
REQ-035 Release reset, pulse btn_ss high for 12 cycles -> running=1. After 100 further ticks, time=00:01.00 (cs=00, s_u=1).
REQ-036 Toggle btn_ss at 1-cycle intervals for 3 cycles then hold low -> exactly one ss event; a second press after the debounce expires -> STOP, time frozen.
REQ-037 In RUN at 00:00.37, press btn_lap -> lap_active=1 and display holds 37 while the live count continues. Press btn_lap again -> display jumps to the live value.
REQ-038 Force time to 59:59.99 in RUN, one tick -> 00:00.00, ovf=1, running=1. Then stop and press lap -> IDLE, ovf=0.
REQ-039 Assert ss and lap edges in the same cycle from RUN -> STOP, lap_active=0. Assert rst_n=0 in LAP -> all REQ-031 values on the next cycle.
REQ-040 Observe an_n over 16 slots -> walking zero 0..7 repeating. Slots 6..7 show seg=0. With CHRONO_LAP_EN undefined, a lap press in RUN leaves state and display unchanged.
